c16_intc: RTL and testbench
===========================

Name: c16_intc

Overview:
- Parametrised multi-source interrupt controller for the c16 CPU. It replaces the core's single ISR-register / single-trigger scheme with NUM_IRQ prioritised, maskable, individually vectored sources.
- Sits between peripheral IRQ lines and the core:
  - The core polls int_req in its check-interrupt state.
  - The core asserts int_ack when it redirects PC to int_vec, and int_done on RTI.
- Configuration registers are reached through the MMIO write/read path.

Parameters:
NUM_IRQ, 8, number of interrupt sources (1..16)
SYNC_STAGES, 2, synchroniser flops per irq_in line (>=2)
ADDR_W, 5, register address width (2^ADDR_W >= 4+NUM_IRQ)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
irq_in  in  NUM_IRQ  asynchronous interrupt lines from peripherals
reg_wen  in  1  register write strobe (one cycle)
reg_addr  in  ADDR_W  register address
reg_wdata  in  16  register write data
reg_rdata  out  16  combinational read data for reg_addr
int_req  out  1  registered interrupt request to core
int_vec  out  16  ISR address; valid while int_req=1
int_ack  in  1  core accepted the request (single cycle)
int_done  in  1  core executed RTI (single cycle)

Behaviour:
- Register map (16-bit; bits >= NUM_IRQ read 0):
  - 0 ENABLE: R/W mask.
  - 1 PENDING: read = pending; write-1-to-clear, edge-mode bits only.
  - 2 MODE: R/W; 1 = rising-edge, 0 = level.
  - 3 STATUS: RO; bit15 = in-service, bits[3:0] = in-service id.
  - 4+i VEC[i]: R/W per-channel ISR address.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset values: all registers 0, int_req=0, int_vec=0, state IDLE, synchroniser and edge-detect flops 0.
- Synchroniser: each irq_in passes through SYNC_STAGES flops, giving sync[i].
- Pending logic:
  - Edge mode: sync rising edge (sync=1, previous=0) sets pending[i] on the next edge.
  - Level mode: pending[i] tracks sync[i] each cycle.
- Collision rule: edge-set and W1C on the same bit in the same cycle -> set wins.
- Eligible[i] = pending[i] & ENABLE[i] & (VEC[i] != 0). A zero vector means "no handler", matching the core rule isr != 0.
- Winner = lowest-index eligible channel (fixed priority, 0 highest).
- FSM:
  - IDLE:
    - Condition: any eligible channel.
    - Action: latch winner id, int_vec <= VEC[id], int_req <= 1.
    - Next: REQ.
  - REQ, in priority order:
    1. If int_ack: int_req <= 0; clear pending[id] if MODE[id]=1; in-service <= 1; STATUS id <= id; next SERVICE.
    2. Else if eligible[id] has dropped (disable, W1C, level fell, vector zeroed): int_req <= 0; next IDLE (request withdrawn).
    3. Else: hold int_req and int_vec stable. A higher-priority channel arriving does NOT preempt a pending request.
  - SERVICE:
    - Behaviour: no new requests; pending still accumulates.
    - Exit: int_done -> in-service <= 0, next IDLE. The next request can assert on the following cycle.
- No nesting: one interrupt in service at a time.
- Ignored inputs:
  - int_ack outside REQ.
  - int_done outside SERVICE.
  - int_ack and int_done together in REQ: ack is taken, done is ignored.
- Writes to VEC/ENABLE/MODE during SERVICE take effect immediately. They do not alter the latched id.
- Latency: irq_in first sampled high at edge k -> sync high after edge k+SYNC_STAGES-1 -> pending after edge k+SYNC_STAGES -> int_req=1 after edge k+SYNC_STAGES+1. With default SYNC_STAGES=2 this is 4 cycles including the sample edge.
- Reset mid-operation: the next clk edge with resetn=0 returns everything to reset values, dropping int_req and in-service.

Test Plan:
- Basic edge IRQ:
  - Setup: ENABLE=0x0004, MODE=0x0004, VEC[2]=0x0040, pulse irq_in[2] for 1 cycle.
  - Required: int_req=1 with int_vec=0x0040 exactly 4 edges after sample.
  - Ack: int_ack -> int_req=0, STATUS=0x8002, PENDING=0.
  - Done: int_done -> STATUS=0x0002.
- Priority and no preemption:
  - Channels 5 and 1 enabled, edge mode, nonzero vectors, raised same cycle -> int_vec=VEC[1].
  - Raise channel 0 while in REQ -> int_vec stays VEC[1].
  - After ack+done -> next request is VEC[0], then VEC[5].
- Level mode and withdrawal:
  - Level channel 3 held high -> int_req.
  - Drop irq_in[3] before ack -> int_req falls after sync latency; FSM returns to IDLE; PENDING bit3=0.
- Zero vector / mask:
  - Pending with VEC=0 or ENABLE bit=0 -> int_req never asserts.
  - Write nonzero VEC -> int_req next cycle.
- W1C and collision: write PENDING=0x0010 on the same cycle that edge 4 is detected -> bit4 remains 1.
- Reset during SERVICE: assert resetn=0 one cycle -> int_req=0, STATUS=0, all registers 0; subsequent int_done is ignored.

Source files
------------

// File: rtl/c16_intc_if.sv
// ---------------------------------------------------------------------------
// c16_intc_if
// Bus bundle between the c16 core and its interrupt controller.
//
// Signals:
//   reg_wen    core -> intc  one-cycle register write strobe
//   reg_addr   core -> intc  register address (ADDR_W bits)
//   reg_wdata  core -> intc  register write data
//   reg_rdata  intc -> core  combinational read data for reg_addr
//   int_req    intc -> core  registered interrupt request
//   int_vec    intc -> core  ISR address, valid while int_req = 1
//   int_ack    core -> intc  core redirected PC to int_vec (one cycle)
//   int_done   core -> intc  core executed RTI (one cycle)
//
// Modports:
//   master  core side
//   slave   interrupt controller side
// ---------------------------------------------------------------------------
interface c16_intc_if #(
    parameter int ADDR_W = 5
);
    logic              reg_wen;
    logic [ADDR_W-1:0] reg_addr;
    logic [15:0]       reg_wdata;
    logic [15:0]       reg_rdata;
    logic              int_req;
    logic [15:0]       int_vec;
    logic              int_ack;
    logic              int_done;

    modport master (
        output reg_wen, reg_addr, reg_wdata, int_ack, int_done,
        input  reg_rdata, int_req, int_vec
    );

    modport slave (
        input  reg_wen, reg_addr, reg_wdata, int_ack, int_done,
        output reg_rdata, int_req, int_vec
    );
endinterface

// File: rtl/c16_intc.sv
// ---------------------------------------------------------------------------
// c16_intc
// Multi-source interrupt controller for the c16 CPU. NUM_IRQ maskable,
// individually vectored sources with fixed priority (channel 0 highest),
// one interrupt in service at a time.
//
// Ports:
//   clk     clock
//   resetn  synchronous, active-low reset
//   irq_in  asynchronous interrupt lines from peripherals (NUM_IRQ bits)
//   bus     c16_intc_if.slave: register access path and the
//           int_req / int_vec / int_ack / int_done handshake with the core
//
// Register map (16-bit, bits >= NUM_IRQ read 0, unmapped reads 0):
//   0      ENABLE   R/W mask
//   1      PENDING  read pending, write-1-to-clear (edge-mode bits only)
//   2      MODE     R/W, 1 = rising edge, 0 = level
//   3      STATUS   RO, bit15 in-service, bits[3:0] in-service id
//   4+i    VEC[i]   R/W ISR address of channel i
// ---------------------------------------------------------------------------
module c16_intc #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irq_in,
    c16_intc_if.slave          bus
);

    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and edge-detect history
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] sync_pipe [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync;
    logic [NUM_IRQ-1:0] sync_prev;
    logic [NUM_IRQ-1:0] rise;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_pipe[s] <= '0;
            end
            sync_prev <= '0;
        end else begin
            sync_pipe[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_pipe[s] <= sync_pipe[s-1];
            end
            sync_prev <= sync;
        end
    end

    assign sync = sync_pipe[SYNC_STAGES-1];
    assign rise = sync & ~sync_prev;

    // ------------------------------------------------------------------
    // Configuration and pending registers
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_next;
    logic [15:0]        vec [NUM_IRQ];
    logic [NUM_IRQ-1:0] vec_nz;
    logic [NUM_IRQ-1:0] eligible;

    logic               wr_enable;
    logic               wr_pending;
    logic               wr_mode;
    logic [NUM_IRQ-1:0] wr_vec;

    // FSM registers, declared here because the pending logic needs them
    state_t          state;
    state_t          state_next;
    logic            int_req_q;
    logic            int_req_next;
    logic [15:0]     int_vec_q;
    logic [15:0]     int_vec_next;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] cur_id_next;
    logic            in_service;
    logic            in_service_next;
    logic [ID_W-1:0] status_id;
    logic [ID_W-1:0] status_id_next;
    logic            ack_take;

    assign wr_enable  = bus.reg_wen && (bus.reg_addr == ADDR_W'(0));
    assign wr_pending = bus.reg_wen && (bus.reg_addr == ADDR_W'(1));
    assign wr_mode    = bus.reg_wen && (bus.reg_addr == ADDR_W'(2));

    always_comb begin
        wr_vec = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            wr_vec[i] = bus.reg_wen && (bus.reg_addr == ADDR_W'(4 + i));
        end
    end

    assign ack_take = (state == REQ) && bus.int_ack;

    // Edge-mode bits are set by a synchronised rising edge and cleared by
    // W1C or by the acknowledge of that channel; a same-cycle set beats
    // either clear. Level-mode bits simply follow the synchronised line.
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (mode[i]) begin
                pending_next[i] = rise[i] |
                    (pending[i] & ~((wr_pending && bus.reg_wdata[i]) ||
                                    (ack_take && (cur_id == ID_W'(i)))));
            end else begin
                pending_next[i] = sync[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            enable  <= '0;
            mode    <= '0;
            pending <= '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                vec[i] <= '0;
            end
        end else begin
            if (wr_enable) begin
                enable <= bus.reg_wdata[NUM_IRQ-1:0];
            end
            if (wr_mode) begin
                mode <= bus.reg_wdata[NUM_IRQ-1:0];
            end
            pending <= pending_next;
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (wr_vec[i]) begin
                    vec[i] <= bus.reg_wdata;
                end
            end
        end
    end

    // A zero vector means the channel has no handler and never requests.
    always_comb begin
        vec_nz = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            vec_nz[i] = |vec[i];
        end
    end

    assign eligible = pending & enable & vec_nz;

    // ------------------------------------------------------------------
    // Fixed-priority winner: lowest eligible index
    // ------------------------------------------------------------------
    logic            any_eligible;
    logic [ID_W-1:0] win_id;

    assign any_eligible = |eligible;

    always_comb begin
        win_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Request / service FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            int_req_q  <= 1'b0;
            int_vec_q  <= '0;
            cur_id     <= '0;
            in_service <= 1'b0;
            status_id  <= '0;
        end else begin
            state      <= state_next;
            int_req_q  <= int_req_next;
            int_vec_q  <= int_vec_next;
            cur_id     <= cur_id_next;
            in_service <= in_service_next;
            status_id  <= status_id_next;
        end
    end

    // In REQ the latched channel is held even if a higher-priority one
    // arrives; the request is only withdrawn if its own eligibility drops.
    // Acknowledge wins over a simultaneous int_done.
    always_comb begin
        state_next      = state;
        int_req_next    = int_req_q;
        int_vec_next    = int_vec_q;
        cur_id_next     = cur_id;
        in_service_next = in_service;
        status_id_next  = status_id;

        case (state)
            IDLE: begin
                if (any_eligible) begin
                    cur_id_next  = win_id;
                    int_vec_next = vec[win_id];
                    int_req_next = 1'b1;
                    state_next   = REQ;
                end
            end

            REQ: begin
                if (bus.int_ack) begin
                    int_req_next    = 1'b0;
                    in_service_next = 1'b1;
                    status_id_next  = cur_id;
                    state_next      = SERVICE;
                end else if (!eligible[cur_id]) begin
                    int_req_next = 1'b0;
                    state_next   = IDLE;
                end
            end

            SERVICE: begin
                if (bus.int_done) begin
                    in_service_next = 1'b0;
                    state_next      = IDLE;
                end
            end

            default: begin
                int_req_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    assign bus.int_req = int_req_q;
    assign bus.int_vec = int_vec_q;

    // ------------------------------------------------------------------
    // Combinational register read mux
    // ------------------------------------------------------------------
    always_comb begin
        bus.reg_rdata = '0;
        if (bus.reg_addr == ADDR_W'(0)) begin
            bus.reg_rdata = 16'(enable);
        end else if (bus.reg_addr == ADDR_W'(1)) begin
            bus.reg_rdata = 16'(pending);
        end else if (bus.reg_addr == ADDR_W'(2)) begin
            bus.reg_rdata = 16'(mode);
        end else if (bus.reg_addr == ADDR_W'(3)) begin
            bus.reg_rdata = {in_service, 11'b0, 4'(status_id)};
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (bus.reg_addr == ADDR_W'(4 + i)) begin
                    bus.reg_rdata = vec[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_c16_intc.sv
// ---------------------------------------------------------------------------
// tb_c16_intc
// Self-checking bench for c16_intc. Directed scenarios per feature plus a
// randomized phase whose expected service order is derived from the
// priority/eligibility rules (sorted list of eligible channels).
// ---------------------------------------------------------------------------
module tb_c16_intc;

    localparam int NUM_IRQ     = 8;
    localparam int SYNC_STAGES = 2;
    localparam int ADDR_W      = 5;

    logic               clk = 1'b0;
    logic               resetn;
    logic [NUM_IRQ-1:0] irq_in;

    int checks = 0;
    int fails  = 0;

    c16_intc_if #(.ADDR_W(ADDR_W)) bus ();

    c16_intc #(
        .NUM_IRQ    (NUM_IRQ),
        .SYNC_STAGES(SYNC_STAGES),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .irq_in(irq_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_write(input int a, input logic [15:0] d);
        bus.reg_addr  = ADDR_W'(a);
        bus.reg_wdata = d;
        bus.reg_wen   = 1'b1;
        tick(1);
        bus.reg_wen   = 1'b0;
    endtask

    task automatic reg_read(input int a, output logic [15:0] d);
        bus.reg_addr = ADDR_W'(a);
        #1;
        d = bus.reg_rdata;
    endtask

    task automatic pulse_ack();
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        bus.int_done = 1'b1;
        tick(1);
        bus.int_done = 1'b0;
    endtask

    task automatic pulse_irq(input logic [NUM_IRQ-1:0] m);
        irq_in = m;
        tick(1);
        irq_in = '0;
    endtask

    task automatic wait_req(input int max_cycles, output bit got);
        got = 1'b0;
        for (int c = 0; c < max_cycles && !got; c++) begin
            if (bus.int_req === 1'b1) got = 1'b1;
            else tick(1);
        end
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        irq_in       = '0;
        bus.reg_wen  = 1'b0;
        bus.reg_addr = '0;
        bus.reg_wdata = '0;
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [15:0] rd;
        do_reset();
        checks++;
        if (bus.int_req !== 1'b0 || bus.int_vec !== 16'h0) begin
            fails++;
            $display("[TB] FAIL reset_out: got req=%b vec=%h expected req=0 vec=0000", bus.int_req, bus.int_vec);
        end
        for (int a = 0; a < 4 + NUM_IRQ; a++) begin
            reg_read(a, rd);
            checks++;
            if (rd !== 16'h0) begin
                fails++;
                $display("[TB] FAIL reset_reg%0d: got %h expected 0000", a, rd);
            end
            if (a % 4 == 3) tick(1);
        end
    endtask

    task automatic test_registers();
        logic [15:0] rd;
        do_reset();
        reg_write(0, 16'hFFFF);
        reg_read(0, rd);
        checks++;
        if (rd !== 16'h00FF) begin fails++; $display("[TB] FAIL enable_rw: got %h expected 00ff", rd); end
        reg_write(2, 16'hA5A5);
        reg_read(2, rd);
        checks++;
        if (rd !== 16'h00A5) begin fails++; $display("[TB] FAIL mode_rw: got %h expected 00a5", rd); end
        reg_write(11, 16'h1234);
        reg_read(11, rd);
        checks++;
        if (rd !== 16'h1234) begin fails++; $display("[TB] FAIL vec7_rw: got %h expected 1234", rd); end
        reg_write(3, 16'hFFFF);
        reg_read(3, rd);
        checks++;
        if (rd !== 16'h0000) begin fails++; $display("[TB] FAIL status_ro: got %h expected 0000", rd); end
        reg_write(12, 16'hBEEF);
        reg_read(12, rd);
        checks++;
        if (rd !== 16'h0000) begin fails++; $display("[TB] FAIL unmapped12: got %h expected 0000", rd); end
        reg_read(31, rd);
        checks++;
        if (rd !== 16'h0000) begin fails++; $display("[TB] FAIL unmapped31: got %h expected 0000", rd); end
    endtask

    task automatic test_edge_basic();
        logic [15:0] rd;
        do_reset();
        reg_write(0, 16'h0004);
        reg_write(2, 16'h0004);
        reg_write(4 + 2, 16'h0040);
        irq_in[2] = 1'b1;
        tick(1);
        irq_in[2] = 1'b0;
        tick(2);
        checks++;
        if (bus.int_req !== 1'b0) begin fails++; $display("[TB] FAIL edge_early: got req=%b expected 0 at edge 3", bus.int_req); end
        tick(1);
        checks++;
        if (bus.int_req !== 1'b1 || bus.int_vec !== 16'h0040) begin
            fails++;
            $display("[TB] FAIL edge_latency: got req=%b vec=%h expected req=1 vec=0040", bus.int_req, bus.int_vec);
        end
        pulse_ack();
        checks++;
        if (bus.int_req !== 1'b0) begin fails++; $display("[TB] FAIL edge_ack_req: got %b expected 0", bus.int_req); end
        reg_read(3, rd);
        checks++;
        if (rd !== 16'h8002) begin fails++; $display("[TB] FAIL edge_status_svc: got %h expected 8002", rd); end
        reg_read(1, rd);
        checks++;
        if (rd !== 16'h0000) begin fails++; $display("[TB] FAIL edge_pending_clr: got %h expected 0000", rd); end
        pulse_done();
        reg_read(3, rd);
        checks++;
        if (rd !== 16'h0002) begin fails++; $display("[TB] FAIL edge_status_done: got %h expected 0002", rd); end
    endtask

    task automatic test_priority();
        bit got;
        logic [15:0] exp_v [3];
        do_reset();
        reg_write(0, 16'h0023);
        reg_write(2, 16'h0023);
        reg_write(4 + 0, 16'h0100);
        reg_write(4 + 1, 16'h0110);
        reg_write(4 + 5, 16'h0150);
        pulse_irq(8'h22);
        wait_req(10, got);
        checks++;
        if (!got || bus.int_vec !== 16'h0110) begin
            fails++;
            $display("[TB] FAIL prio_first: got req=%b vec=%h expected vec=0110", got, bus.int_vec);
        end
        pulse_irq(8'h01);
        tick(5);
        checks++;
        if (bus.int_req !== 1'b1 || bus.int_vec !== 16'h0110) begin
            fails++;
            $display("[TB] FAIL prio_nopreempt: got req=%b vec=%h expected req=1 vec=0110", bus.int_req, bus.int_vec);
        end
        pulse_ack();
        tick(1);
        pulse_done();
        exp_v[0] = 16'h0100;
        exp_v[1] = 16'h0150;
        for (int k = 0; k < 2; k++) begin
            wait_req(10, got);
            checks++;
            if (!got || bus.int_vec !== exp_v[k]) begin
                fails++;
                $display("[TB] FAIL prio_order%0d: got req=%b vec=%h expected vec=%h", k, got, bus.int_vec, exp_v[k]);
            end
            pulse_ack();
            pulse_done();
        end
        tick(5);
        checks++;
        if (bus.int_req !== 1'b0) begin fails++; $display("[TB] FAIL prio_drained: got req=%b expected 0", bus.int_req); end
    endtask

    task automatic test_level();
        bit got;
        logic [15:0] rd;
        do_reset();
        reg_write(0, 16'h0008);
        reg_write(4 + 3, 16'h0330);
        irq_in[3] = 1'b1;
        wait_req(10, got);
        checks++;
        if (!got || bus.int_vec !== 16'h0330) begin
            fails++;
            $display("[TB] FAIL level_req: got req=%b vec=%h expected vec=0330", got, bus.int_vec);
        end
        tick(3);
        irq_in[3] = 1'b0;
        tick(3);
        checks++;
        if (bus.int_req !== 1'b1) begin fails++; $display("[TB] FAIL level_hold: got req=%b expected 1", bus.int_req); end
        tick(1);
        checks++;
        if (bus.int_req !== 1'b0) begin fails++; $display("[TB] FAIL level_withdraw: got req=%b expected 0", bus.int_req); end
        reg_read(1, rd);
        checks++;
        if (rd !== 16'h0000) begin fails++; $display("[TB] FAIL level_pending: got %h expected 0000", rd); end
        tick(4);
        checks++;
        if (bus.int_req !== 1'b0) begin fails++; $display("[TB] FAIL level_idle: got req=%b expected 0", bus.int_req); end
    endtask

    task automatic test_zero_vec_mask();
        logic [15:0] rd;
        do_reset();
        reg_write(2, 16'h0040);
        reg_write(0, 16'h0040);
        pulse_irq(8'h40);
        tick(6);
        checks++;
        if (bus.int_req !== 1'b0) begin fails++; $display("[TB] FAIL zvec_noreq: got req=%b expected 0", bus.int_req); end
        reg_read(1, rd);
        checks++;
        if (rd !== 16'h0040) begin fails++; $display("[TB] FAIL zvec_pending: got %h expected 0040", rd); end
        pulse_ack();
        reg_read(3, rd);
        checks++;
        if (rd !== 16'h0000) begin fails++; $display("[TB] FAIL ack_idle_ignored: got %h expected 0000", rd); end
        reg_write(4 + 6, 16'h0660);
        checks++;
        if (bus.int_req !== 1'b0) begin fails++; $display("[TB] FAIL zvec_same: got req=%b expected 0", bus.int_req); end
        tick(1);
        checks++;
        if (bus.int_req !== 1'b1 || bus.int_vec !== 16'h0660) begin
            fails++;
            $display("[TB] FAIL zvec_next: got req=%b vec=%h expected req=1 vec=0660", bus.int_req, bus.int_vec);
        end
        pulse_ack();
        pulse_done();
        reg_write(0, 16'h0000);
        pulse_irq(8'h40);
        tick(5);
        checks++;
        if (bus.int_req !== 1'b0) begin fails++; $display("[TB] FAIL mask_noreq: got req=%b expected 0", bus.int_req); end
        reg_write(0, 16'h0040);
        tick(1);
        checks++;
        if (bus.int_req !== 1'b1 || bus.int_vec !== 16'h0660) begin
            fails++;
            $display("[TB] FAIL mask_enable: got req=%b vec=%h expected req=1 vec=0660", bus.int_req, bus.int_vec);
        end
        pulse_ack();
        pulse_done();
    endtask

    task automatic test_collision();
        logic [15:0] rd;
        do_reset();
        reg_write(2, 16'h0010);
        pulse_irq(8'h10);
        tick(4);
        reg_read(1, rd);
        checks++;
        if (rd !== 16'h0010) begin fails++; $display("[TB] FAIL coll_preset: got %h expected 0010", rd); end
        irq_in[4] = 1'b1;
        tick(1);
        irq_in[4] = 1'b0;
        tick(1);
        reg_write(1, 16'h0010);
        reg_read(1, rd);
        checks++;
        if (rd !== 16'h0010) begin fails++; $display("[TB] FAIL coll_setwins: got %h expected 0010", rd); end
        reg_write(1, 16'h0010);
        reg_read(1, rd);
        checks++;
        if (rd !== 16'h0000) begin fails++; $display("[TB] FAIL w1c_clear: got %h expected 0000", rd); end
        irq_in[0] = 1'b1;
        tick(4);
        reg_write(1, 16'h0001);
        reg_read(1, rd);
        checks++;
        if (rd !== 16'h0001) begin fails++; $display("[TB] FAIL w1c_level_ignored: got %h expected 0001", rd); end
        irq_in[0] = 1'b0;
        tick(4);
    endtask

    task automatic test_reset_service();
        bit got;
        logic [15:0] rd;
        do_reset();
        reg_write(0, 16'h0004);
        reg_write(2, 16'h0004);
        reg_write(4 + 2, 16'h0040);
        pulse_irq(8'h04);
        wait_req(10, got);
        pulse_ack();
        reg_read(3, rd);
        checks++;
        if (!got || rd !== 16'h8002) begin fails++; $display("[TB] FAIL rst_svc_setup: got req_seen=%b status=%h expected 8002", got, rd); end
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        checks++;
        if (bus.int_req !== 1'b0) begin fails++; $display("[TB] FAIL rst_svc_req: got %b expected 0", bus.int_req); end
        for (int a = 0; a < 4 + NUM_IRQ; a++) begin
            reg_read(a, rd);
            checks++;
            if (rd !== 16'h0) begin fails++; $display("[TB] FAIL rst_svc_reg%0d: got %h expected 0000", a, rd); end
            if (a % 4 == 3) tick(1);
        end
        pulse_done();
        tick(2);
        reg_read(3, rd);
        checks++;
        if (rd !== 16'h0000 || bus.int_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rst_svc_done_ignored: got status=%h req=%b expected 0000/0", rd, bus.int_req);
        end
    endtask

    task automatic test_random();
        bit got;
        logic [15:0] rd;
        logic [NUM_IRQ-1:0] raised, en, served;
        logic [15:0] vecs [NUM_IRQ];
        int exp_q [$];
        int id;
        for (int it = 0; it < 12; it++) begin
            do_reset();
            raised = NUM_IRQ'($urandom_range(1, 255));
            en     = NUM_IRQ'($urandom);
            served = '0;
            exp_q.delete();
            for (int i = 0; i < NUM_IRQ; i++) begin
                vecs[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
                reg_write(4 + i, vecs[i]);
            end
            reg_write(2, 16'h00FF);
            reg_write(0, 16'(en));
            // Expected service order: ascending index among eligible channels
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (raised[i] && en[i] && vecs[i] != 16'h0) begin
                    exp_q.push_back(i);
                    served[i] = 1'b1;
                end
            end
            pulse_irq(raised);
            while (exp_q.size() > 0) begin
                id = exp_q.pop_front();
                wait_req(12, got);
                checks++;
                if (!got || bus.int_vec !== vecs[id]) begin
                    fails++;
                    $display("[TB] FAIL rand_vec it%0d ch%0d: got req=%b vec=%h expected vec=%h", it, id, got, bus.int_vec, vecs[id]);
                end
                tick($urandom_range(0, 3));
                pulse_ack();
                reg_read(3, rd);
                checks++;
                if (rd !== (16'h8000 | 16'(id))) begin
                    fails++;
                    $display("[TB] FAIL rand_status it%0d: got %h expected %h", it, rd, 16'h8000 | 16'(id));
                end
                tick($urandom_range(0, 3));
                pulse_done();
            end
            tick(6);
            checks++;
            if (bus.int_req !== 1'b0) begin fails++; $display("[TB] FAIL rand_drained it%0d: got req=%b expected 0", it, bus.int_req); end
            reg_read(1, rd);
            checks++;
            if (rd !== 16'(raised & ~served)) begin
                fails++;
                $display("[TB] FAIL rand_pending it%0d: got %h expected %h", it, rd, 16'(raised & ~served));
            end
        end
    endtask

    initial begin
        $display("[TB] starting c16_intc bench");
        test_reset();
        test_registers();
        test_edge_basic();
        test_priority();
        test_level();
        test_zero_vec_mask();
        test_collision();
        test_reset_service();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
